blink_rate_decoder: RTL



---
 rtl/blink_rate_decoder_if.sv | 47 ++++
 rtl/blink_rate_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/blink_rate_decoder_if.sv
// -----------------------------------------------------------------------------
// blink_rate_decoder_if
//
// Groups the control input, the sensed square wave and the measurement results
// of blink_rate_decoder. Clock and reset are not part of this bundle.
//
//   i_enable       0 forces the decoder idle and discards the partial period
//   i_led_sense    asynchronous square wave being measured
//   o_rate_code    11=1Hz, 10=10Hz, 01=50Hz, 00=100Hz; last locked code
//   o_valid        high while the decoder is locked
//   o_code_strobe  one-cycle pulse on each entry to lock
//   o_period       last measured full period, in clocks
//   o_active       high while measuring or locked
//
// Modports:
//   master - drives enable / sense, observes results (bench, system logic)
//   slave  - the decoder itself
// -----------------------------------------------------------------------------
interface blink_rate_decoder_if;
    logic        i_enable;
    logic        i_led_sense;
    logic [1:0]  o_rate_code;
    logic        o_valid;
    logic        o_code_strobe;
    logic [31:0] o_period;
    logic        o_active;

    modport master (
        output i_enable,
        output i_led_sense,
        input  o_rate_code,
        input  o_valid,
        input  o_code_strobe,
        input  o_period,
        input  o_active
    );

    modport slave (
        input  i_enable,
        input  i_led_sense,
        output o_rate_code,
        output o_valid,
        output o_code_strobe,
        output o_period,
        output o_active
    );
endinterface

// File: rtl/blink_rate_decoder.sv
// -----------------------------------------------------------------------------
// blink_rate_decoder
//
// Receive-side companion of the switch-selected LED blink generator. Measures
// the period of an external square wave in i_clock cycles, classifies it as
// 100/50/10/1 Hz using the generator's 2-bit switch code and raises a lock
// flag once the same class has been seen c_LOCK_COUNT periods in a row.
//
// Ports:
//   i_clock   system clock
//   i_reset   synchronous, active-high reset
//   if_rate   blink_rate_decoder_if.slave (enable, sense input, results)
//
// Optional build macro:
//   BLINK_DUTY_CHECK_EN - also measures the high time of every period and
//   only classifies a period whose high time is within c_k >> (c_TOL_SHIFT-1)
//   of the class half-period. Undefined: duty cycle is ignored.
// -----------------------------------------------------------------------------
module blink_rate_decoder #(
    parameter int unsigned c_CNT_100HZ   = 125,
    parameter int unsigned c_CNT_50HZ    = 250,
    parameter int unsigned c_CNT_10HZ    = 1250,
    parameter int unsigned c_CNT_1HZ     = 12500,
    parameter int unsigned c_TOL_SHIFT   = 3,
    parameter int unsigned c_LOCK_COUNT  = 2,
    parameter int unsigned c_CNT_TIMEOUT = 50000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    blink_rate_decoder_if.slave  if_rate
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] code;
    } class_t;

    localparam int unsigned c_MATCH_W = $clog2(c_LOCK_COUNT + 1);

    localparam logic [c_MATCH_W-1:0] c_LOCK_MATCH   = c_MATCH_W'(c_LOCK_COUNT);
    localparam logic [31:0]          c_TIMEOUT_LAST = 32'(c_CNT_TIMEOUT - 1);

    // Half-periods indexed by rate code: 00=100Hz, 01=50Hz, 10=10Hz, 11=1Hz.
    localparam logic [31:0] c_HALF [4] = '{c_CNT_100HZ, c_CNT_50HZ, c_CNT_10HZ, c_CNT_1HZ};

    // |value - nominal| <= nominal >> shift, evaluated without signed math.
    function automatic logic in_window(input logic [32:0] value,
                                       input logic [32:0] nominal,
                                       input int unsigned shift);
        logic [32:0] tol;
        tol = nominal >> shift;
        return (value + tol >= nominal) && (value <= nominal + tol);
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizer and edge detect
    // r_sync[0], r_sync[1] form the 2-FF synchronizer; r_sync[2] is the
    // previous synchronized level used for edge detection.
    // ------------------------------------------------------------------
    logic [2:0] r_sync;
    logic       w_rise;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the values from before the clock edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], if_rate.i_led_sense};
        end
    end

    assign w_rise = r_sync[1] & ~r_sync[2];

    // ------------------------------------------------------------------
    // Optional high-time measurement
    // ------------------------------------------------------------------
`ifdef BLINK_DUTY_CHECK_EN
    logic        w_fall;
    logic [31:0] r_high_count;
    logic [31:0] r_high_time;

    assign w_fall = ~r_sync[1] & r_sync[2];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_high_count <= '0;
            r_high_time  <= '0;
        end else begin
            if (w_rise) begin
                r_high_count <= '0;
            end else if (r_high_count != '1) begin
                r_high_count <= r_high_count + 32'd1;
            end
            // High time counts the rising-pulse cycle itself, like the period.
            if (w_fall) begin
                r_high_time <= (r_high_count == '1) ? r_high_count : r_high_count + 32'd1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Period measurement and classification
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [31:0]            r_count;
    logic [c_MATCH_W-1:0]   r_match;
    logic [1:0]             r_last_code;
    logic [1:0]             r_rate_code;
    logic                   r_valid;
    logic                   r_strobe;
    logic [31:0]            r_period;
    logic                   r_active;

    logic [32:0]            w_period;
    class_t                 w_class;
    logic [c_MATCH_W-1:0]   w_match_next;
    logic                   w_stay_locked;

    // The counter is cleared on the edge pulse, so the edge cycle itself
    // belongs to the period just ending.
    assign w_period = {1'b0, r_count} + 33'd1;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_class = '0;
        for (int k = 0; k < 4; k++) begin
            if (in_window(w_period, {c_HALF[k], 1'b0}, c_TOL_SHIFT)
`ifdef BLINK_DUTY_CHECK_EN
                && in_window({1'b0, r_high_time}, {1'b0, c_HALF[k]}, c_TOL_SHIFT - 1)
`endif
            ) begin
                w_class.hit  = 1'b1;
                w_class.code = 2'(k);
            end
        end
    end

    assign w_stay_locked = (r_state == ST_LOCKED) && w_class.hit &&
                           (w_class.code == r_last_code);

    // Run length of identical classes; an unclassified period breaks the run.
    always_comb begin
        w_match_next = '0;
        if (w_class.hit) begin
            if ((r_match != '0) && (w_class.code == r_last_code)) begin
                w_match_next = r_match + c_MATCH_W'(1);
            end else begin
                w_match_next = c_MATCH_W'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_match     <= '0;
            r_last_code <= '0;
            r_rate_code <= '0;
            r_valid     <= 1'b0;
            r_strobe    <= 1'b0;
            r_period    <= '0;
            r_active    <= 1'b0;
        end else if (!if_rate.i_enable) begin
            // Rate code and last period are kept for inspection while disabled.
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_match  <= '0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The first edge only re-arms: no period is known yet.
                    r_count <= '0;
                    if (w_rise) begin
                        r_state  <= ST_MEASURE;
                        r_active <= 1'b1;
                        r_match  <= '0;
                    end
                end

                default: begin
                    if (w_rise) begin
                        // An edge on the timeout cycle is processed as a period.
                        r_count  <= '0;
                        r_period <= w_period[31:0];
                        if (!w_stay_locked) begin
                            r_match <= w_match_next;
                            if (w_class.hit) begin
                                r_last_code <= w_class.code;
                            end
                            if (w_match_next == c_LOCK_MATCH) begin
                                r_state     <= ST_LOCKED;
                                r_valid     <= 1'b1;
                                r_strobe    <= 1'b1;
                                r_rate_code <= w_class.code;
                            end else begin
                                r_state <= ST_MEASURE;
                                r_valid <= 1'b0;
                            end
                        end
                    end else if (r_count == c_TIMEOUT_LAST) begin
                        r_state  <= ST_IDLE;
                        r_count  <= '0;
                        r_match  <= '0;
                        r_valid  <= 1'b0;
                        r_active <= 1'b0;
                    end else if (r_count != '1) begin
                        r_count <= r_count + 32'd1;
                    end
                end
            endcase
        end
    end

    assign if_rate.o_rate_code   = r_rate_code;
    assign if_rate.o_valid       = r_valid;
    assign if_rate.o_code_strobe = r_strobe;
    assign if_rate.o_period      = r_period;
    assign if_rate.o_active      = r_active;

endmodule
